// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_COUNT,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // 3 * 255 payload bytes needs 10 bits (last index 764)
  localparam int CNT_W = 10;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream receive handshake plus instruction-memory byte write port.
interface program_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [7:0]        im_wdata;

  // master: the loader; slave: host link source and memory sink
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Parses SYNC/BASE/N/payload/CHK frames, writes payload bytes to instruction
// memory and holds the CPU until a frame with a good checksum has landed.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | drop bytes until SYNC
// ST_ADDR_HI | capture BASE[15:8]
// ST_ADDR_LO | capture BASE[7:0]
// ST_COUNT   | capture word count N (N = 0 is an error)
// ST_PAYLOAD | write each byte to BASE+k, fold into XOR checksum
// ST_CHECK   | compare received CHK against accumulated XOR
// ST_DONE    | one stall cycle after a good frame
// ST_ERROR   | one stall cycle after a rejected frame
module program_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W = 16,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  program_loader_if.master        bus,
  output logic                    cpu_hold,
  output logic                    load_done,
  output logic                    load_err
);

  loader_state_e     state_q, state_d;
  logic              rx_ready_q;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [7:0]        im_wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        base_hi_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  last_q;
  logic [7:0]        chk_q;

  logic accept;
  logic sync_acc;
  logic pay_acc;
  logic enter_done;
  logic enter_err;

  assign accept = bus.rx_valid & rx_ready_q;

  always_comb begin
    state_d    = state_q;
    sync_acc   = 1'b0;
    pay_acc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && bus.rx_data == SYNC) begin
          state_d  = ST_ADDR_HI;
          sync_acc = 1'b1;
        end
      end
      ST_ADDR_HI: if (accept) state_d = ST_ADDR_LO;
      ST_ADDR_LO: if (accept) state_d = ST_COUNT;
      ST_COUNT: begin
        if (accept) state_d = (bus.rx_data == 8'd0) ? ST_ERROR : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (accept) begin
          pay_acc = 1'b1;
          if (cnt_q == last_q) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (accept) state_d = (bus.rx_data == chk_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign enter_done = (state_q == ST_CHECK) && (state_d == ST_DONE);
  assign enter_err  = (state_q != ST_ERROR) && (state_d == ST_ERROR);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      // registered so the single stall lands in the DONE/ERROR cycle itself
      rx_ready_q <= !(state_d inside {ST_DONE, ST_ERROR});
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      addr_q     <= '0;
      base_hi_q  <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      chk_q      <= '0;
    end else begin
      im_we_q <= pay_acc;
      if (sync_acc) begin
        chk_q <= '0;
        cnt_q <= '0;
      end
      if (state_q == ST_ADDR_HI && accept) base_hi_q <= bus.rx_data;
      if (state_q == ST_ADDR_LO && accept) addr_q <= ADDR_W'({base_hi_q, bus.rx_data});
      if (state_q == ST_COUNT && accept) begin
        last_q <= ({2'b00, bus.rx_data} << 1) + {2'b00, bus.rx_data} - CNT_W'(1);
      end
      if (pay_acc) begin
        im_addr_q  <= addr_q;
        im_wdata_q <= bus.rx_data;
        addr_q     <= addr_q + 1'b1;
        cnt_q      <= cnt_q + 1'b1;
        chk_q      <= chk_q ^ bus.rx_data;
      end
    end
  end

  // Status: a failed frame keeps the CPU held since memory may be half written
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (sync_acc) begin
        cpu_hold  <= 1'b1;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end
      if (enter_done) begin
        cpu_hold  <= 1'b0;
        load_done <= 1'b1;
      end
      if (enter_err) load_err <= 1'b1;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven frames, random frames
// against a frame-level model, and hand-written reset/noise sequences.
module tb_program_loader;
  import loader_pkg::*;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  logic cpu_hold, load_done, load_err;

  always #5 Clock = ~Clock;

  program_loader_if #(.ADDR_W(16)) bus ();

  program_loader #(.ADDR_W(16), .SYNC(8'hA5)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] base;
    int          n;
    logic [23:0] w0;
    logic [23:0] w1;
    logic [7:0]  chk;
    bit          exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one byte, wait (bounded) for acceptance, then check the write
  // port in the cycle right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit exp_we,
                           input logic [15:0] ea, input int gap);
    int w;
    for (int g = 0; g < gap; g++) begin
      @(negedge Clock);
      bus.rx_valid = 1'b0;
    end
    @(negedge Clock);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    w = 0;
    while (!bus.rx_ready && w < 100) begin
      @(negedge Clock);
      w++;
    end
    if (!bus.rx_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.rx_valid = 1'b0;
      return;
    end
    @(posedge Clock);
    #1;
    bus.rx_valid = 1'b0;
    check("im_we", bus.im_we, exp_we);
    if (exp_we) begin
      check("im_addr", bus.im_addr, ea);
      check("im_wdata", bus.im_wdata, b);
    end
  endtask

  task automatic send_frame(input logic [15:0] base, input int n,
                            input logic [7:0] pl[$], input logic [7:0] chk,
                            input bit exp_done, input int maxgap);
    send_byte(8'hA5, 1'b0, 16'h0, $urandom_range(maxgap, 0));
    check("sync_hold", cpu_hold, 1'b1);
    check("sync_done_clr", load_done, 1'b0);
    check("sync_err_clr", load_err, 1'b0);
    send_byte(base[15:8], 1'b0, 16'h0, $urandom_range(maxgap, 0));
    send_byte(base[7:0], 1'b0, 16'h0, $urandom_range(maxgap, 0));
    send_byte(8'(n), 1'b0, 16'h0, $urandom_range(maxgap, 0));
    if (n == 0) begin
      check("n0_err", load_err, 1'b1);
      check("n0_done", load_done, 1'b0);
      check("n0_hold", cpu_hold, 1'b1);
      check("n0_stall", bus.rx_ready, 1'b0);
      return;
    end
    for (int k = 0; k < 3 * n; k++)
      send_byte(pl[k], 1'b1, base + 16'(k), $urandom_range(maxgap, 0));
    send_byte(chk, 1'b0, 16'h0, $urandom_range(maxgap, 0));
    check("load_done", load_done, exp_done);
    check("load_err", load_err, !exp_done);
    check("cpu_hold", cpu_hold, !exp_done);
    check("stall_after_chk", bus.rx_ready, 1'b0);
    @(posedge Clock);
    #1;
    check("ready_after_stall", bus.rx_ready, 1'b1);
  endtask

  // Frame-level model: split words MSB first into payload bytes, XOR them.
  function automatic void build_payload(input logic [23:0] words[$],
                                        output logic [7:0] pl[$],
                                        output logic [7:0] x);
    pl = {};
    x  = 8'h00;
    foreach (words[i]) begin
      pl.push_back(words[i][23:16]);
      pl.push_back(words[i][15:8]);
      pl.push_back(words[i][7:0]);
    end
    foreach (pl[i]) x ^= pl[i];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pl[$];
    logic [23:0] words[$];
    logic [7:0]  x;
    logic [7:0]  chk;
    logic [15:0] base;
    int          n;
    bit          corrupt;

    vecs[0] = '{16'h000A, 1, 24'h123456, 24'h0, 8'h70, 1'b1};
    vecs[1] = '{16'h000A, 1, 24'h123456, 24'h0, 8'h71, 1'b0};
    vecs[2] = '{16'hFFFF, 1, 24'hAABBCC, 24'h0, 8'hDD, 1'b1};
    vecs[3] = '{16'h0100, 2, 24'h010203, 24'h0A0B0C, 8'h0D, 1'b1};
    vecs[4] = '{16'h0000, 0, 24'h0, 24'h0, 8'h00, 1'b0};
    vecs[5] = '{16'h0020, 1, 24'hA5A5A5, 24'h0, 8'hA5, 1'b1};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    repeat (3) @(negedge Clock);
    check("rst_rx_ready", bus.rx_ready, 1'b0);
    check("rst_im_we", bus.im_we, 1'b0);
    check("rst_im_addr", bus.im_addr, 16'h0);
    check("rst_cpu_hold", cpu_hold, 1'b1);
    check("rst_load_done", load_done, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;
    check("post_rst_ready", bus.rx_ready, 1'b1);

    send_byte(8'h00, 1'b0, 16'h0, 0);
    send_byte(8'hFF, 1'b0, 16'h0, 0);
    check("noise_hold", cpu_hold, 1'b1);
    check("noise_done", load_done, 1'b0);

    foreach (vecs[i]) begin
      words = {};
      if (vecs[i].n >= 1) words.push_back(vecs[i].w0);
      if (vecs[i].n >= 2) words.push_back(vecs[i].w1);
      build_payload(words, pl, x);
      send_frame(vecs[i].base, vecs[i].n, pl, vecs[i].chk, vecs[i].exp_done, 0);
    end

    // Status is sticky across idle noise.
    send_byte(8'h3C, 1'b0, 16'h0, 1);
    check("sticky_done", load_done, 1'b1);
    check("sticky_hold", cpu_hold, 1'b0);

    for (int r = 0; r < 8; r++) begin
      base  = 16'($urandom);
      n     = $urandom_range(4, 1);
      words = {};
      for (int j = 0; j < n; j++) words.push_back(24'($urandom));
      build_payload(words, pl, x);
      corrupt = 1'($urandom_range(1, 0));
      chk = corrupt ? (x ^ 8'($urandom_range(255, 1))) : x;
      send_frame(base, n, pl, chk, !corrupt, 3);
    end

    // Reset after the second payload byte of a good frame.
    send_byte(8'hA5, 1'b0, 16'h0, 0);
    send_byte(8'h00, 1'b0, 16'h0, 0);
    send_byte(8'h10, 1'b0, 16'h0, 0);
    send_byte(8'h01, 1'b0, 16'h0, 0);
    send_byte(8'h11, 1'b1, 16'h0010, 0);
    send_byte(8'h22, 1'b1, 16'h0011, 0);
    @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.rx_ready, 1'b0);
    check("mid_rst_we", bus.im_we, 1'b0);
    check("mid_rst_addr", bus.im_addr, 16'h0);
    check("mid_rst_wdata", bus.im_wdata, 8'h0);
    check("mid_rst_hold", cpu_hold, 1'b1);
    check("mid_rst_done", load_done, 1'b0);
    check("mid_rst_err", load_err, 1'b0);
    @(negedge Clock);
    Reset_n = 1'b1;

    words = {24'h123456};
    build_payload(words, pl, x);
    send_frame(16'h000A, 1, pl, x, 1'b1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream loader that writes 24-bit program words into the byte-addressed instruction memory read by the CPU datapath. It parses a framed stream from a host link (UART receiver or test harness), writes each payload byte straight to the instruction memory write port, and holds the CPU until a frame with a valid checksum has been fully written. It is the writer side of the instruction-memory interface; the datapath fetch path is the reader.

## Interface
Parameters:
- ADDR_W, 16, instruction-memory byte-address width; addresses wrap modulo 2^ADDR_W.
- SYNC, 8'hA5, frame start byte.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts rx_data; a byte transfers when rx_valid & rx_ready at a rising edge.
- im_we  out  1  instruction-memory byte write strobe.
- im_addr  out  ADDR_W  instruction-memory byte address.
- im_wdata  out  8  byte to write.
- cpu_hold  out  1  holds the CPU (PC and register writes frozen) while high.
- load_done  out  1  last frame loaded with a good checksum (sticky).
- load_err  out  1  last frame rejected (sticky).

## Operation
- Frame format: SYNC, BASE_HI, BASE_LO, N (word count), 3·N payload bytes, CHK.
- BASE is a big-endian 16-bit byte address, truncated to ADDR_W.
- Each 24-bit word is sent MSB first. Byte k of the payload (k = 0 … 3N−1) is written to BASE+k, so instruction[23:16] lands at the lowest address.
- CHK is the XOR of all 3·N payload bytes.
- States:
  - IDLE: non-SYNC bytes are dropped; SYNC goes to ADDR_HI.
  - ADDR_HI, then ADDR_LO: capture BASE.
  - COUNT: N = 0 goes to ERROR; otherwise go to PAYLOAD.
  - PAYLOAD: write each byte and fold it into the checksum; the last byte (counter = 3N−1) goes to CHECK.
  - CHECK: compare the received CHK; match goes to DONE, mismatch goes to ERROR.
  - DONE / ERROR: one-cycle status states, then back to IDLE.
- Accepting SYNC in IDLE:
  - sets cpu_hold = 1 and clears load_done and load_err;
  - clears the checksum accumulator and the byte counter (10 bits, max 764).
- DONE sets load_done = 1 and cpu_hold = 0.
- ERROR sets load_err = 1; cpu_hold stays 1, because a partially written program must not run.
- Bytes already written by a failed frame are not rolled back.
- A SYNC value seen inside ADDR/COUNT/PAYLOAD/CHECK is treated as data, not a restart.
- Address wrap: BASE+k wraps at 2^ADDR_W with no error.

## Timing
- Reset values: rx_ready 0, im_we 0, im_addr 0, im_wdata 0, cpu_hold 1, load_done 0, load_err 0, state IDLE.
- rx_ready:
  - 1 in IDLE, ADDR_HI, ADDR_LO, COUNT, PAYLOAD and CHECK;
  - 0 in DONE and ERROR, so there is exactly one stall cycle after CHK.
- Write latency: a payload byte accepted at edge t produces im_we = 1 with im_addr/im_wdata valid for the cycle after edge t, i.e. exactly one cycle.
- im_we is 0 in every cycle without a preceding payload accept.
- Back-to-back payload bytes give one write per cycle.
- rx_valid gaps stall the FSM with no timeout.
- Status timing: load_done/load_err and the cpu_hold release take effect at the edge that leaves CHECK, i.e. the edge that accepts CHK.
- Reset asserted mid-frame returns every output to its reset value immediately. The frame is abandoned and the next frame must start with SYNC.

## Structure
- Shared package loader_pkg holds:
  - the state enumeration (IDLE, ADDR_HI, ADDR_LO, COUNT, PAYLOAD, CHECK, DONE, ERROR);
  - the SYNC default;
  - the counter width constant.
- No sub-module: one FSM with an address register, byte counter and XOR accumulator.
- At top level, cpu_hold gates the datapath PC update and RegWrite.

## Test plan
- Reset: Reset_n = 0 → cpu_hold = 1, im_we = 0, rx_ready = 0; release → rx_ready = 1.
- Good frame A5 00 0A 01 12 34 56 CHK = 70 → writes 12 @ 0x0A, 34 @ 0x0B, 56 @ 0x0C, each one cycle after its accept; load_done = 1, cpu_hold = 0.
- Bad checksum: same frame with CHK = 71 → the three writes occur, then load_err = 1, cpu_hold stays 1, load_done = 0.
- Noise and N = 0:
  - bytes 00 FF before A5 produce no writes;
  - frame A5 00 00 00 → load_err = 1 and no payload is consumed.
- Wrap and gaps (ADDR_W = 16):
  - BASE = FFFF, N = 1, payload AA BB CC → writes AA @ FFFF, BB @ 0000, CC @ 0001;
  - random rx_valid gaps do not change the written data.
- Reset after the second payload byte of a good frame → outputs return to reset values; a following complete frame loads correctly.
